softmax_tile_sched: RTL
=======================

Name: softmax_tile_sched

Overview:
- Sequences one score tile at a time through the softmax datapath: score-block beats in, exponentiated pi beats out.
- Accepts a tile command and clears the running row max before the tile's first beat.
- Gates exactly cmd_len score beats into softmax, then counts the matching pi beats out and pulses tile_done.
- Sits between the QK column-block result stream and the softmax input, and between the softmax pi output and the PV stage.

Parameters:
- PARALLEL_ROW, 32, FP16 lanes per input score beat.
- PARALLEL_COL, 32, FP16 lanes per pi output beat.
- FP_WIDTH, 16, bits per lane.
- K_MACRO_ROW, 32, maximum beats per tile; cmd_len range is 1..K_MACRO_ROW.
- BEATS_PER_OUT, 2, input beats packed into one pi beat.
- LEN_W, 6, width of cmd_len; LEN_W >= clog2(K_MACRO_ROW+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_vld  in  1  tile command valid
- cmd_rdy  out  1  tile command ready
- cmd_len  in  LEN_W  input beats in this tile
- up_vld  in  1  score beat valid
- up_rdy  out  1  score beat ready
- up_data  in  PARALLEL_ROW*FP_WIDTH  score beat
- sm_in_vld  out  1  to softmax input valid
- sm_in_rdy  in  1  softmax input ready
- sm_in_data  out  PARALLEL_ROW*FP_WIDTH  score beat to softmax
- max_clr  out  1  one-cycle clear of the softmax running max
- sm_out_vld  in  1  pi valid from softmax
- sm_out_rdy  out  1  pi ready to softmax
- sm_out_data  in  PARALLEL_COL*FP_WIDTH  pi from softmax
- dn_vld  out  1  pi valid downstream
- dn_rdy  in  1  downstream ready
- dn_data  out  PARALLEL_COL*FP_WIDTH  pi downstream
- busy  out  1  tile in flight
- tile_done  out  1  one-cycle pulse at tile completion
- err  out  2  sticky flags: [0] bad cmd_len, [1] spurious pi

Behaviour:
- Reset is asynchronous and active-high on rst. On reset:
  - state=IDLE; in_cnt=0; out_cnt=0; len_q=0.
  - All outputs 0, except cmd_rdy=1 (combinational in IDLE).
  - Reset mid-tile abandons the tile and produces no tile_done.
- States: IDLE, CLR, FEED, DRAIN, DONE.
- IDLE:
  - cmd_rdy=1.
  - cmd_vld&cmd_rdy with valid cmd_len: latch len_q; go to CLR.
  - cmd_len is valid when 1..K_MACRO_ROW and a multiple of BEATS_PER_OUT.
  - Invalid cmd_len: command is consumed, err[0] sets, state stays IDLE.
- CLR:
  - max_clr=1 for exactly this one cycle; go to FEED.
  - Command handshake at cycle T gives max_clr at T+1 and earliest up_rdy at T+2.
- FEED:
  - sm_in_vld=up_vld; up_rdy=sm_in_rdy; sm_in_data=up_data. Combinational path, no added latency.
  - in_cnt increments on each sm_in handshake.
  - On the handshake where in_cnt==len_q-1, go to DRAIN; up_rdy=0 from the next cycle.
- pi path, active in FEED and DRAIN:
  - dn_vld=sm_out_vld; sm_out_rdy=dn_rdy; dn_data=sm_out_data.
  - out_cnt increments on each dn handshake.
  - pi beats arriving during FEED are forwarded and counted.
- DRAIN:
  - up_rdy=0; sm_in_vld=0.
  - On the dn handshake where out_cnt==len_q/BEATS_PER_OUT-1, go to DONE.
  - If that final handshake happens in FEED in the same cycle as the last input handshake, go straight to DONE.
- DONE:
  - tile_done=1 for one cycle; counters clear; go to IDLE.
  - cmd_rdy is 0 in DONE. Back-to-back tiles therefore cost one bubble cycle.
- busy=1 in every state except IDLE.
- In IDLE, CLR and DONE: sm_out_rdy=0, dn_vld=0. If sm_out_vld=1 in any of these states, err[1] sets.
- err bits are sticky until rst.
- Counters never wrap, because len_q <= K_MACRO_ROW < 2^LEN_W.

Optional Feature:
- Macro: SOFTMAX_SCHED_PERF_EN.
- When defined, adds output perf_stall [31:0].
  - Counts cycles where busy=1 and neither an sm_in handshake nor a dn handshake occurs.
  - Saturates at 0xFFFFFFFF; clears on rst only.
- When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Nominal tile:
  - Stimulus: cmd_len=32; up_vld, sm_in_rdy and dn_rdy held 1; softmax model returns 16 pi beats.
  - Required: max_clr at T+1; exactly 32 sm_in handshakes starting at T+2; 16 dn beats forwarded unchanged; tile_done 1 cycle after the 16th dn beat; busy falls with it.
- Backpressure:
  - Stimulus: cmd_len=4; sm_in_rdy toggles 1,0,1,0; dn_rdy=0 for 5 cycles.
  - Required: up_rdy mirrors sm_in_rdy; no beat lost or duplicated; tile_done only after 2 dn handshakes.
- Bad command:
  - Stimulus: cmd_len=0, then cmd_len=3.
  - Required: both consumed in 1 cycle each; err[0]=1; no max_clr; state remains IDLE; next cmd_len=2 tile completes normally.
- Spurious pi:
  - Stimulus: sm_out_vld=1 while IDLE.
  - Required: sm_out_rdy=0; dn_vld=0; err[1]=1 and stays 1 through later tiles.
- Same-cycle finish:
  - Stimulus: cmd_len=2 with the final pi handshake in the same cycle as the last input handshake.
  - Required: FEED to DONE directly; single tile_done.
- Reset mid-FEED:
  - Stimulus: assert rst after 10 of 32 beats; release; issue a new cmd_len=8.
  - Required: no tile_done for the aborted tile; new tile sees max_clr and completes with 4 pi beats.
  - With SOFTMAX_SCHED_PERF_EN: perf_stall=0 after reset.

Source files
------------

// File: rtl/softmax_tile_sched.sv
// Tile sequencer between the QK score stream, softmax and the PV stage.
// Define SOFTMAX_SCHED_PERF_EN to add the perf_stall cycle counter output.
module softmax_tile_sched #(
    parameter int PARALLEL_ROW  = 32,
    parameter int PARALLEL_COL  = 32,
    parameter int FP_WIDTH      = 16,
    parameter int K_MACRO_ROW   = 32,
    parameter int BEATS_PER_OUT = 2,
    parameter int LEN_W         = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_vld,
    output logic                             cmd_rdy,
    input  logic [LEN_W-1:0]                 cmd_len,
    input  logic                             up_vld,
    output logic                             up_rdy,
    input  logic [PARALLEL_ROW*FP_WIDTH-1:0] up_data,
    output logic                             sm_in_vld,
    input  logic                             sm_in_rdy,
    output logic [PARALLEL_ROW*FP_WIDTH-1:0] sm_in_data,
    output logic                             max_clr,
    input  logic                             sm_out_vld,
    output logic                             sm_out_rdy,
    input  logic [PARALLEL_COL*FP_WIDTH-1:0] sm_out_data,
    output logic                             dn_vld,
    input  logic                             dn_rdy,
    output logic [PARALLEL_COL*FP_WIDTH-1:0] dn_data,
    output logic                             busy,
    output logic                             tile_done,
    output logic [1:0]                       err
`ifdef SOFTMAX_SCHED_PERF_EN
    ,
    output logic [31:0]                      perf_stall
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [LEN_W-1:0] KMAX = LEN_W'(K_MACRO_ROW);
    localparam logic [LEN_W-1:0] BPO  = LEN_W'(BEATS_PER_OUT);
    localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic [LEN_W-1:0] len_q;
    logic             feed;
    logic             pi_act;
    logic             cmd_hs;
    logic             len_ok;
    logic             in_hs;
    logic             dn_hs;
    logic             in_last;
    logic             out_last;

    assign feed   = (state_q == FEED);
    assign pi_act = (state_q == FEED) || (state_q == DRAIN);

    assign cmd_rdy   = (state_q == IDLE);
    assign max_clr   = (state_q == CLR);
    assign busy      = (state_q != IDLE);
    assign tile_done = (state_q == DONE);

    assign sm_in_vld  = feed & up_vld;
    assign up_rdy     = feed & sm_in_rdy;
    assign sm_in_data = feed ? up_data : '0;

    assign dn_vld     = pi_act & sm_out_vld;
    assign sm_out_rdy = pi_act & dn_rdy;
    assign dn_data    = pi_act ? sm_out_data : '0;

    assign cmd_hs = cmd_vld & cmd_rdy;
    assign len_ok = (cmd_len != '0) && (cmd_len <= KMAX)
                 && ((cmd_len % BPO) == '0);
    assign in_hs  = sm_in_vld & sm_in_rdy;
    assign dn_hs  = dn_vld & dn_rdy;

    // Last-beat detection against the latched tile length
    assign in_last  = in_hs && (in_cnt == len_q - ONE);
    assign out_last = dn_hs && (out_cnt == (len_q / BPO) - ONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_hs && len_ok) state_d = CLR;
            CLR:     state_d = FEED;
            FEED:    if (in_last) state_d = out_last ? DONE : DRAIN;
            DRAIN:   if (out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            len_q   <= '0;
            err     <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_hs && len_ok) len_q <= cmd_len;
            if (state_q == DONE) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (in_hs) in_cnt <= in_cnt + 1'b1;
                if (dn_hs) out_cnt <= out_cnt + 1'b1;
            end
            if (cmd_hs && !len_ok) err[0] <= 1'b1;
            // pi with no tile able to accept it
            if (sm_out_vld && !pi_act) err[1] <= 1'b1;
        end
    end

`ifdef SOFTMAX_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
        end else if (busy && !in_hs && !dn_hs && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
